// File: rtl/ub_port_arbiter.sv
// ---------------------------------------------------------------------------
// ub_port_arbiter
//
// Shares one single-port buffer memory between a host (single-beat accesses)
// and an engine (bursts of 1..4 beats). Grants and the memory port drive are
// combinational from the winning requester. Read data comes back one cycle
// after the read enable and is routed to whichever requester issued that read.
//
// Parameters
//   ADDR_W : buffer word address width
//   DATA_W : data width per beat
//
// Ports
//   clk, rst                       clock, synchronous active-low reset
//   host_req/we/addr/wdata         host single-beat request
//   host_gnt                       host beat accepted this cycle
//   host_rvalid/host_rdata         host read response
//   eng_req/we/addr/len/wdata      engine burst request (we/addr/len taken
//                                  on the first beat only)
//   eng_gnt, eng_done              engine beat accepted / last beat
//   eng_rvalid/eng_rdata           engine read response
//   mem_en/we/addr/wdata/rdata     buffer memory port
//   busy                           engine burst in progress (after beat 0)
// ---------------------------------------------------------------------------
module ub_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              eng_req,
  input  logic              eng_we,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic [1:0]        eng_len,
  input  logic [DATA_W-1:0] eng_wdata,
  output logic              eng_gnt,
  output logic              eng_done,
  output logic              eng_rvalid,
  output logic [DATA_W-1:0] eng_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic {
    IDLE      = 1'b0,
    ENG_BURST = 1'b1
  } state_e;

  state_e              state_q;
  logic                ptr_q;        // 0: host wins a tie, 1: engine wins
  logic [1:0]          cnt_q;        // index of the next engine beat
  logic [1:0]          len_q;        // captured burst length minus one
  logic [ADDR_W-1:0]   base_q;       // captured burst base address
  logic                we_q;         // captured burst direction
  logic                rd_pend_q;    // a read was issued last cycle
  logic                rd_eng_q;     // owner of that read: 1 = engine
  logic [DATA_W-1:0]   host_rdata_q; // last delivered host read data
  logic [DATA_W-1:0]   eng_rdata_q;  // last delivered engine read data

  logic                beat_we;
  logic [ADDR_W-1:0]   beat_addr;
  logic                beat_last;

  // Grant decode and memory port drive. Everything is forced low while in
  // reset so the outputs read zero even before the first clock edge.
  always_comb begin
    host_gnt  = 1'b0;
    eng_gnt   = 1'b0;
    beat_we   = 1'b0;
    beat_addr = '0;
    beat_last = 1'b0;
    if (rst) begin
      if (state_q == ENG_BURST) begin
        // Burst owns the port; fields come from the captured copy so that
        // changes on eng_we/eng_addr/eng_len mid-burst have no effect.
        eng_gnt   = eng_req;
        beat_addr = base_q + ADDR_W'(cnt_q);
        beat_we   = we_q;
        beat_last = (cnt_q == len_q);
      end else begin
        host_gnt  = host_req && (!eng_req || !ptr_q);
        eng_gnt   = eng_req && !host_gnt;
        beat_addr = eng_addr;
        beat_we   = eng_we;
        beat_last = (eng_len == 2'd0);
      end
    end
  end

  always_comb begin
    mem_en    = host_gnt || eng_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (host_gnt) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else if (eng_gnt) begin
      mem_we    = beat_we;
      mem_addr  = beat_addr;
      mem_wdata = eng_wdata;
    end
  end

  assign eng_done    = eng_gnt && beat_last;
  assign busy        = rst && (state_q == ENG_BURST);

  // Read responses: memory data is valid the cycle after the read, so it is
  // passed straight through to the tagged owner and also held for later.
  assign host_rvalid = rst && rd_pend_q && !rd_eng_q;
  assign eng_rvalid  = rst && rd_pend_q && rd_eng_q;
  assign host_rdata  = !rst ? '0 : (host_rvalid ? mem_rdata : host_rdata_q);
  assign eng_rdata   = !rst ? '0 : (eng_rvalid ? mem_rdata : eng_rdata_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      cnt_q        <= 2'd0;
      len_q        <= 2'd0;
      base_q       <= '0;
      we_q         <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_eng_q     <= 1'b0;
      host_rdata_q <= '0;
      eng_rdata_q  <= '0;
    end else begin
      rd_pend_q <= mem_en && !mem_we;
      rd_eng_q  <= eng_gnt;
      if (host_rvalid) host_rdata_q <= mem_rdata;
      if (eng_rvalid)  eng_rdata_q  <= mem_rdata;

      if (host_gnt) ptr_q <= 1'b1;

      if (eng_gnt) begin
        if (state_q == IDLE) begin
          base_q <= eng_addr;
          len_q  <= eng_len;
          we_q   <= eng_we;
        end
        if (beat_last) begin
          // Burst complete: hand the next tie back to the host.
          state_q <= IDLE;
          ptr_q   <= 1'b0;
          cnt_q   <= 2'd0;
        end else begin
          state_q <= ENG_BURST;
          cnt_q   <= cnt_q + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ub_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ub_port_arbiter
//
// Directed stimulus for ub_port_arbiter. A behavioural model (engine burst as
// a queue of remaining beat addresses, a tie-break flag and a pending-read
// record) predicts every output each cycle; a compare process checks them.
// Directed literal expectations pin key cycles independently of the model.
// The bench also plays the buffer memory: read data is a fixed function of
// the address, presented one cycle after the read.
// ---------------------------------------------------------------------------
module tb_ub_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          eng_req, eng_we;
  logic [AW-1:0] eng_addr;
  logic [1:0]    eng_len;
  logic [DW-1:0] eng_wdata;
  logic          eng_gnt, eng_done, eng_rvalid;
  logic [DW-1:0] eng_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ub_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata),
    .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_len(eng_len),
    .eng_wdata(eng_wdata), .eng_gnt(eng_gnt), .eng_done(eng_done),
    .eng_rvalid(eng_rvalid), .eng_rdata(eng_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return {a, ~a, a ^ 16'h1234, 16'hC0DE};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [AW-1:0] m_q[$];      // addresses of engine beats still to come
  logic          m_bwe;       // direction of the open burst
  logic          m_engfirst;  // engine wins the next tie
  logic          m_rd_pend, m_rd_eng;
  logic [AW-1:0] m_rd_addr;
  logic [DW-1:0] m_hold_h, m_hold_e;

  logic          e_hg, e_eg, e_done, e_busy, e_en, e_we, e_hrv, e_erv;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd, e_hrd, e_erd;

  logic          s_rd;
  logic [AW-1:0] s_addr;
  logic [15:0]   junk_cnt = 16'd0;

  task automatic model_eval();
    e_hg = 0; e_eg = 0; e_done = 0; e_busy = 0; e_en = 0; e_we = 0;
    e_hrv = 0; e_erv = 0; e_addr = '0; e_wd = '0; e_hrd = '0; e_erd = '0;
    if (rst) begin
      e_busy = (m_q.size() != 0);
      if (e_busy) begin
        e_eg   = eng_req;
        e_done = eng_req && (m_q.size() == 1);
      end else if (host_req && (!eng_req || !m_engfirst)) begin
        e_hg = 1;
      end else if (eng_req) begin
        e_eg   = 1;
        e_done = (eng_len == 2'd0);
      end
      if (e_hg) begin
        e_en = 1; e_we = host_we; e_addr = host_addr; e_wd = host_wdata;
      end else if (e_eg) begin
        e_en = 1;
        e_we = e_busy ? m_bwe : eng_we;
        e_addr = e_busy ? m_q[0] : eng_addr;
        e_wd = eng_wdata;
      end
      e_hrv = m_rd_pend && !m_rd_eng;
      e_erv = m_rd_pend && m_rd_eng;
      e_hrd = e_hrv ? memf(m_rd_addr) : m_hold_h;
      e_erd = e_erv ? memf(m_rd_addr) : m_hold_e;
    end
  endtask

  task automatic model_commit();
    if (!rst) begin
      m_q.delete();
      m_bwe = 0; m_engfirst = 0; m_rd_pend = 0; m_rd_eng = 0; m_rd_addr = '0;
      m_hold_h = '0; m_hold_e = '0;
    end else begin
      if (e_hrv) m_hold_h = e_hrd;
      if (e_erv) m_hold_e = e_erd;
      m_rd_pend = e_en && !e_we;
      m_rd_eng  = e_eg;
      m_rd_addr = e_addr;
      if (e_hg) m_engfirst = 1;
      if (e_eg) begin
        if (!e_busy) begin
          m_bwe = eng_we;
          for (int k = 1; k <= int'(eng_len); k++) m_q.push_back(eng_addr + AW'(k));
        end else begin
          void'(m_q.pop_front());
        end
        if (m_q.size() == 0) m_engfirst = 0;
      end
    end
  endtask

  // Compare process: sample mid-low-phase, commit model on the rising edge,
  // then present memory read data for the read issued in that cycle.
  initial begin
    m_q.delete();
    m_bwe = 0; m_engfirst = 0; m_rd_pend = 0; m_rd_eng = 0; m_rd_addr = '0;
    m_hold_h = '0; m_hold_e = '0;
    forever begin
      @(negedge clk);
      #3;
      model_eval();
      chk("host_gnt", DW'(host_gnt), DW'(e_hg));
      chk("eng_gnt", DW'(eng_gnt), DW'(e_eg));
      chk("eng_done", DW'(eng_done), DW'(e_done));
      chk("busy", DW'(busy), DW'(e_busy));
      chk("mem_en", DW'(mem_en), DW'(e_en));
      chk("mem_we", DW'(mem_we), DW'(e_we));
      chk("mem_addr", DW'(mem_addr), DW'(e_addr));
      chk("mem_wdata", mem_wdata, e_wd);
      chk("host_rvalid", DW'(host_rvalid), DW'(e_hrv));
      chk("host_rdata", host_rdata, e_hrd);
      chk("eng_rvalid", DW'(eng_rvalid), DW'(e_erv));
      chk("eng_rdata", eng_rdata, e_erd);
      s_rd   = mem_en && !mem_we;
      s_addr = mem_addr;
      @(posedge clk);
      model_commit();
      #1;
      junk_cnt++;
      mem_rdata = s_rd ? memf(s_addr) : {48'hBAD0_BAD0_BAD0, junk_cnt};
    end
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic drv(input logic hr, input logic hw, input logic [AW-1:0] ha,
                     input logic [DW-1:0] hd, input logic er, input logic ew,
                     input logic [AW-1:0] ea, input logic [1:0] el,
                     input logic [DW-1:0] ed);
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    eng_req = er; eng_we = ew; eng_addr = ea; eng_len = el; eng_wdata = ed;
  endtask

  initial begin
    rst = 1'b0;
    drv(1, 1, 16'h0040, 64'h11, 1, 1, 16'h0080, 2'd0, 64'h22);

    // Reset holds everything low even with both requesting.
    nxt(); nxt(); #1;
    chk("rst host_gnt", DW'(host_gnt), 0);
    chk("rst eng_gnt", DW'(eng_gnt), 0);
    chk("rst mem_en", DW'(mem_en), 0);
    chk("rst mem_addr", DW'(mem_addr), 0);
    chk("rst busy", DW'(busy), 0);
    nxt();

    // Both request from reset: host, engine, host, engine.
    rst = 1'b1;
    #1; chk("tie1 host_gnt", DW'(host_gnt), 1); chk("tie1 eng_gnt", DW'(eng_gnt), 0);
    nxt(); #1; chk("tie2 eng_gnt", DW'(eng_gnt), 1); chk("tie2 eng_done", DW'(eng_done), 1);
    chk("tie2 mem_addr", DW'(mem_addr), 64'h80);
    nxt(); #1; chk("tie3 host_gnt", DW'(host_gnt), 1);
    nxt(); #1; chk("tie4 eng_gnt", DW'(eng_gnt), 1);

    // Host write 0xAA at 0x0010, engine idle.
    nxt(); drv(1, 1, 16'h0010, 64'hAA, 0, 0, 16'h0, 2'd0, 64'h0);
    #1; chk("hw host_gnt", DW'(host_gnt), 1); chk("hw mem_en", DW'(mem_en), 1);
    chk("hw mem_we", DW'(mem_we), 1); chk("hw mem_addr", DW'(mem_addr), 64'h10);
    chk("hw mem_wdata", mem_wdata, 64'hAA);

    // Engine write burst of 4 at 0x0100; host read held; mid-burst field changes ignored.
    nxt(); drv(1, 0, 16'h0055, 64'h0, 1, 1, 16'h0100, 2'd3, 64'hE0);
    #1; chk("ew0 addr", DW'(mem_addr), 64'h100); chk("ew0 busy", DW'(busy), 0);
    chk("ew0 host_gnt", DW'(host_gnt), 0);
    for (int b = 1; b <= 3; b++) begin
      nxt(); drv(1, 0, 16'h0055, 64'h0, 1, 0, 16'hBEEF, 2'd0, 64'hE0 + DW'(b));
      #1; chk("ewb addr", DW'(mem_addr), 64'h100 + DW'(b));
      chk("ewb we", DW'(mem_we), 1); chk("ewb busy", DW'(busy), 1);
      chk("ewb host_gnt", DW'(host_gnt), 0);
      chk("ewb done", DW'(eng_done), (b == 3) ? 64'd1 : 64'd0);
    end
    nxt(); drv(1, 0, 16'h0055, 64'h0, 0, 0, 16'h0, 2'd0, 64'h0);
    #1; chk("ew5 host_gnt", DW'(host_gnt), 1); chk("ew5 busy", DW'(busy), 0);

    // Engine read wrapping 0xFFFE..0x0001, then a host read right behind it.
    nxt(); drv(0, 0, 16'h0, 64'h0, 1, 0, 16'hFFFE, 2'd3, 64'h0);
    #1; chk("er0 addr", DW'(mem_addr), 64'hFFFE);
    chk("er0 host_rvalid", DW'(host_rvalid), 1); chk("er0 host_rdata", host_rdata, memf(16'h0055));
    nxt(); #1; chk("er1 addr", DW'(mem_addr), 64'hFFFF);
    chk("er1 eng_rvalid", DW'(eng_rvalid), 1); chk("er1 eng_rdata", eng_rdata, memf(16'hFFFE));
    nxt(); #1; chk("er2 addr", DW'(mem_addr), 64'h0000);
    chk("er2 eng_rdata", eng_rdata, memf(16'hFFFF));
    nxt(); #1; chk("er3 addr", DW'(mem_addr), 64'h0001); chk("er3 done", DW'(eng_done), 1);
    chk("er3 eng_rdata", eng_rdata, memf(16'h0000));
    nxt(); drv(1, 0, 16'h0033, 64'h0, 0, 0, 16'h0, 2'd0, 64'h0);
    #1; chk("er4 host_gnt", DW'(host_gnt), 1); chk("er4 eng_rdata", eng_rdata, memf(16'h0001));
    chk("er4 host_rvalid", DW'(host_rvalid), 0);
    nxt(); drv(0, 0, 16'h0, 64'h0, 0, 0, 16'h0, 2'd0, 64'h0);
    #1; chk("er5 host_rvalid", DW'(host_rvalid), 1); chk("er5 host_rdata", host_rdata, memf(16'h0033));
    chk("er5 eng_rvalid", DW'(eng_rvalid), 0); chk("er5 eng_rdata hold", eng_rdata, memf(16'h0001));

    // Paused burst: engine drops req for two cycles, host stays blocked.
    nxt(); drv(1, 1, 16'h0077, 64'h99, 1, 1, 16'h0200, 2'd3, 64'hA0);
    #1; chk("ep0 addr", DW'(mem_addr), 64'h200); chk("ep0 host_gnt", DW'(host_gnt), 0);
    nxt(); drv(1, 1, 16'h0077, 64'h99, 1, 1, 16'h0200, 2'd3, 64'hA1);
    #1; chk("ep1 addr", DW'(mem_addr), 64'h201);
    for (int p = 0; p < 2; p++) begin
      nxt(); drv(1, 1, 16'h0077, 64'h99, 0, 1, 16'h0200, 2'd3, 64'h0);
      #1; chk("pause mem_en", DW'(mem_en), 0); chk("pause host_gnt", DW'(host_gnt), 0);
      chk("pause busy", DW'(busy), 1);
    end
    nxt(); drv(1, 1, 16'h0077, 64'h99, 1, 1, 16'h0200, 2'd3, 64'hA2);
    #1; chk("ep2 addr", DW'(mem_addr), 64'h202); chk("ep2 wdata", mem_wdata, 64'hA2);
    nxt(); drv(1, 1, 16'h0077, 64'h99, 1, 1, 16'h0200, 2'd3, 64'hA3);
    #1; chk("ep3 addr", DW'(mem_addr), 64'h203); chk("ep3 done", DW'(eng_done), 1);
    nxt(); drv(1, 1, 16'h0077, 64'h99, 0, 0, 16'h0, 2'd0, 64'h0);
    #1; chk("ep4 host_gnt", DW'(host_gnt), 1); chk("ep4 addr", DW'(mem_addr), 64'h77);

    // Reset mid-burst after beat 2: burst abandoned, host first after release.
    nxt(); drv(0, 0, 16'h0, 64'h0, 1, 0, 16'h0300, 2'd3, 64'h0);
    #1; chk("ea0 addr", DW'(mem_addr), 64'h300);
    nxt(); #1; chk("ea1 addr", DW'(mem_addr), 64'h301);
    nxt(); #1; chk("ea2 addr", DW'(mem_addr), 64'h302);
    for (int r = 0; r < 2; r++) begin
      nxt(); rst = 1'b0; drv(1, 1, 16'h0044, 64'h5, 1, 0, 16'h0300, 2'd3, 64'h0);
      #1; chk("ra eng_done", DW'(eng_done), 0); chk("ra eng_gnt", DW'(eng_gnt), 0);
      chk("ra host_gnt", DW'(host_gnt), 0); chk("ra busy", DW'(busy), 0);
      chk("ra eng_rvalid", DW'(eng_rvalid), 0); chk("ra eng_rdata", eng_rdata, 0);
    end
    nxt(); rst = 1'b1;
    #1; chk("rel host_gnt", DW'(host_gnt), 1); chk("rel eng_gnt", DW'(eng_gnt), 0);
    chk("rel busy", DW'(busy), 0);

    nxt(); drv(0, 0, 16'h0, 64'h0, 0, 0, 16'h0, 2'd0, 64'h0);
    nxt(); nxt();
    #4;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
